// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: program counter and branch sequencer for the ONC-16 core
//   clock   in   rising-edge system clock
//   n_rst   in   asynchronous active-low reset
//   stall   in   hold pc and flush counter
//   bre     in   branch taken (already gated with decode enable)
//   br_link in   with bre, also capture pc+1 into link
//   br_tgt  in   branch target (absolute, or signed offset with PC_REL_BR_EN)
//   pc      out  current fetch address
//   flush   out  kill younger in-flight instructions
//   link    out  return address of last linked branch
//   busy    out  high while flushing
// Build option PC_REL_BR_EN: branch target is pc + br_tgt instead of br_tgt.
module pc_branch_ctrl #(
   parameter int              PC_W      = 16,
   parameter logic [PC_W-1:0] RST_VEC   = '0,
   parameter int              FLUSH_CYC = 2
) (
   input  logic            clock,
   input  logic            n_rst,
   input  logic            stall,
   input  logic            bre,
   input  logic            br_link,
   input  logic [PC_W-1:0] br_tgt,
   output logic [PC_W-1:0] pc,
   output logic            flush,
   output logic [PC_W-1:0] link,
   output logic            busy
);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic [PC_W-1:0] pc_nx, link_nx, tgt, pc_inc;
   logic flush_nx;
   assign pc_inc = pc + PC_W'(1);
`ifdef PC_REL_BR_EN
   assign tgt = pc + br_tgt;
`else
   assign tgt = br_tgt;
`endif
   assign busy = flush;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pc_nx    = pc;
      link_nx  = link;
      flush_nx = flush;
      if (state == RUN) begin
         // a taken branch wins over stall so the redirect is never lost
         if (bre) begin
            pc_nx    = tgt;
            flush_nx = 1'b1;
            cnt_nx   = 3'(FLUSH_CYC - 1);
            state_nx = FLUSH;
            link_nx  = br_link ? pc_inc : link;
         end else begin
            pc_nx = stall ? pc : pc_inc;
         end
      end else if (!stall) begin
         // bre here belongs to an instruction being flushed, so it is ignored
         pc_nx    = pc_inc;
         cnt_nx   = (cnt != 3'd0) ? cnt - 3'd1 : cnt;
         flush_nx = (cnt != 3'd0);
         state_nx = (cnt != 3'd0) ? FLUSH : RUN;
      end
   end
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         state <= RUN;
         cnt   <= '0;
         pc    <= RST_VEC;
         link  <= '0;
         flush <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         pc    <= pc_nx;
         link  <= link_nx;
         flush <= flush_nx;
      end
   end
endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb_pc_branch_ctrl: directed self-checking bench for pc_branch_ctrl
module tb_pc_branch_ctrl;
   logic clock, n_rst, stall, bre, br_link;
   logic [15:0] br_tgt, pc, link;
   logic flush, busy;
   int n_chk = 0;
   int n_pass = 0;

   pc_branch_ctrl dut (
      .clock(clock), .n_rst(n_rst), .stall(stall), .bre(bre), .br_link(br_link),
      .br_tgt(br_tgt), .pc(pc), .flush(flush), .link(link), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h want %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // branch operand that makes the target land on want from the given pc
   function automatic logic [15:0] enc(input logic [15:0] cur, input logic [15:0] want);
`ifdef PC_REL_BR_EN
      return want - cur;
`else
      return want;
`endif
   endfunction

   initial begin
      n_rst = 1'b0; stall = 1'b0; bre = 1'b0; br_link = 1'b0; br_tgt = '0;
      #2;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_flush", flush, 1'b0);
      chk("rst_link", link, 16'h0000);
      chk("rst_busy", busy, 1'b0);
      @(negedge clock);
      n_rst = 1'b1;
      chk("seq_pc0", pc, 16'h0000);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("seq_pc", pc, 32'(i));
      end
      chk("seq_link", link, 16'h0000);
      repeat (11) step();
      chk("pre_t3_pc", pc, 16'h0010);
      // T3 absolute branch with link
      bre = 1'b1; br_link = 1'b1; br_tgt = enc(16'h0010, 16'h0100);
      step();
      bre = 1'b0; br_link = 1'b0;
      chk("t3_pc", pc, 16'h0100);
      chk("t3_link", link, 16'h0011);
      chk("t3_flush1", flush, 1'b1);
      chk("t3_busy1", busy, 1'b1);
      step();
      chk("t3_pc2", pc, 16'h0101);
      chk("t3_flush2", flush, 1'b1);
      step();
      chk("t3_pc3", pc, 16'h0102);
      chk("t3_flush3", flush, 1'b0);
      chk("t3_busy3", busy, 1'b0);
      step();
      chk("t3_pc4", pc, 16'h0103);
      // T4 stall in first flush cycle, bre during FLUSH ignored
      bre = 1'b1; br_tgt = enc(16'h0103, 16'h0100);
      step();
      chk("t4_pc", pc, 16'h0100);
      chk("t4_link_kept", link, 16'h0011);
      chk("t4_flush1", flush, 1'b1);
      stall = 1'b1; br_tgt = 16'h0200;
      step();
      chk("t4_pc_held", pc, 16'h0100);
      chk("t4_flush2", flush, 1'b1);
      stall = 1'b0;
      step();
      chk("t4_pc2", pc, 16'h0101);
      chk("t4_flush3", flush, 1'b1);
      bre = 1'b0;
      step();
      chk("t4_pc3", pc, 16'h0102);
      chk("t4_flush_end", flush, 1'b0);
      // br_link alone has no effect
      br_link = 1'b1;
      step();
      br_link = 1'b0;
      chk("link_nobre", link, 16'h0011);
      chk("link_nobre_pc", pc, 16'h0103);
      // T1 reset mid-flush
      bre = 1'b1; br_tgt = enc(16'h0103, 16'h0500);
      step();
      bre = 1'b0;
      chk("t1_pre_flush", flush, 1'b1);
      #1 n_rst = 1'b0;
      #1;
      chk("t1_pc", pc, 16'h0000);
      chk("t1_flush", flush, 1'b0);
      chk("t1_link", link, 16'h0000);
      chk("t1_busy", busy, 1'b0);
      @(negedge clock);
      n_rst = 1'b1;
      step();
      chk("t1_run_pc", pc, 16'h0001);
      chk("t1_run_flush", flush, 1'b0);
      // T5 wrap: branch to FFFD, flush drains, RUN wraps FFFF -> 0000
      bre = 1'b1; br_tgt = enc(16'h0001, 16'hFFFD);
      step();
      bre = 1'b0;
      chk("t5_pc_fffd", pc, 16'hFFFD);
      step();
      step();
      chk("t5_pc_ffff", pc, 16'hFFFF);
      chk("t5_run", flush, 1'b0);
      step();
      chk("t5_wrap", pc, 16'h0000);
      step();
      step();
      chk("t5_pc2", pc, 16'h0002);
      bre = 1'b1; br_link = 1'b1;
`ifdef PC_REL_BR_EN
      br_tgt = 16'hFFFC;
`else
      br_tgt = 16'hFFFE;
`endif
      step();
      bre = 1'b0; br_link = 1'b0;
      chk("t5_tgt", pc, 16'hFFFE);
      chk("t5_link", link, 16'h0003);
      step();
      step();
      chk("t5_drain_pc", pc, 16'h0000);
      chk("t5_drain_flush", flush, 1'b0);
      // RUN stall holds pc
      stall = 1'b1;
      step();
      chk("run_stall_pc", pc, 16'h0000);
      chk("run_stall_flush", flush, 1'b0);
      // T6 bre beats stall in RUN
      bre = 1'b1; br_tgt = enc(16'h0000, 16'h0040);
      step();
      bre = 1'b0;
      chk("t6_pc", pc, 16'h0040);
      chk("t6_flush", flush, 1'b1);
      step();
      chk("t6_hold", pc, 16'h0040);
      stall = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   always @(posedge clock)
      if (n_rst && $isunknown(bre)) begin
         n_chk++;
         $display("FAIL bre_x: got %b want 0 or 1", bre);
      end
endmodule
